// File: rtl/seq_det_pkg.sv
// Shared types and helpers for the serial pattern detector.
package seq_det_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILL   = 2'd1,
    DETECT = 2'd2
  } det_state_e;

  // Width needed to hold a pattern length in the range 0..pat_w.
  function automatic int len_width(input int pat_w);
    return $clog2(pat_w + 1);
  endfunction

  function automatic int clamp_len(input int len, input int pat_w);
    if (len < 1) return 1;
    if (len > pat_w) return pat_w;
    return len;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter; a clear in the same cycle as an increment leaves 1.
module sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= inc ? CNT_W'(1) : '0;
    end else if (inc && (cnt != CNT_MAX)) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/seq_pattern_detector.sv
// Runtime-programmable serial pattern detector with overlap control and match statistics.
module seq_pattern_detector
  import seq_det_pkg::*;
#(
  parameter int PAT_W = 8,
  parameter int CNT_W = 8,
  parameter int LEN_W = len_width(PAT_W)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             x,
  input  logic             x_valid,
  input  logic             cfg_load,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             cfg_overlap,
  input  logic             cnt_clr,
  output logic             y,
  output logic             armed,
  output logic [CNT_W-1:0] match_cnt
);

  det_state_e       state_q, state_d;
  logic [PAT_W-1:0] pat_q, pat_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             ovl_q, ovl_d;
  logic [PAT_W-1:0] hist_q, hist_d;
  logic [LEN_W-1:0] fill_q, fill_d;
  logic             y_q;

  logic [PAT_W-1:0] hist_next;
  logic [PAT_W-1:0] len_mask;
  logic [LEN_W-1:0] fill_inc;
  logic             sample;
  logic             window_full;
  logic             match;

  assign hist_next = {hist_q[PAT_W-2:0], x};
  // Shifting all-ones by len clears exactly the compared bits, including len == PAT_W.
  assign len_mask  = ~({PAT_W{1'b1}} << len_q);
  assign fill_inc  = fill_q + LEN_W'(1);

  assign sample      = x_valid && !cfg_load && (state_q != IDLE);
  assign window_full = (state_q == DETECT) || (fill_inc == len_q);
  assign match       = sample && window_full && (((hist_next ^ pat_q) & len_mask) == '0);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    len_d   = len_q;
    ovl_d   = ovl_q;
    hist_d  = hist_q;
    fill_d  = fill_q;

    if (cfg_load) begin
      pat_d   = cfg_pattern;
      len_d   = LEN_W'(clamp_len(int'(cfg_len), PAT_W));
      ovl_d   = cfg_overlap;
      hist_d  = '0;
      fill_d  = '0;
      state_d = FILL;
    end else if (sample) begin
      hist_d = hist_next;
      if (state_q == FILL) begin
        fill_d = fill_inc;
        if (fill_inc == len_q) state_d = DETECT;
      end
      // Non-overlapping mode restarts the window so no bit is shared between matches.
      if (match && !ovl_q) begin
        hist_d  = '0;
        fill_d  = '0;
        state_d = FILL;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      pat_q   <= '0;
      len_q   <= '0;
      ovl_q   <= 1'b0;
      hist_q  <= '0;
      fill_q  <= '0;
      y_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      len_q   <= len_d;
      ovl_q   <= ovl_d;
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      y_q     <= match;
    end
  end

  sat_counter #(
    .CNT_W(CNT_W)
  ) u_match_cnt (
    .clk(clk),
    .rst(rst),
    .inc(match),
    .clr(cnt_clr),
    .cnt(match_cnt)
  );

  assign y     = y_q;
  assign armed = (state_q != IDLE);

endmodule

// File: tb/tb_seq_pattern_detector.sv
// Scoreboard bench: a bit-history model predicts y/armed/match_cnt for every driven cycle.
module tb_seq_pattern_detector;

  localparam int PAT_W = 8;
  localparam int LEN_W = $clog2(PAT_W + 1);

  logic             clk = 1'b0;
  logic             rst;
  logic             x, x_valid, cfg_load, cfg_overlap, cnt_clr;
  logic [PAT_W-1:0] cfg_pattern;
  logic [LEN_W-1:0] cfg_len;
  logic             y, armed, y2, armed2;
  logic [7:0]       match_cnt;
  logic [1:0]       match_cnt2;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic       y;
    logic       armed;
    logic [7:0] cnt;
    logic [1:0] cnt2;
    string      tag;
  } exp_t;

  exp_t sb[$];

  // Reference model state: raw bits received since the last flush.
  logic       m_bits[$];
  logic       m_armed;
  logic [7:0] m_pat;
  int         m_len;
  logic       m_ovl;
  logic [7:0] m_cnt;
  logic [1:0] m_cnt2;

  always #5 clk = ~clk;

  seq_pattern_detector #(.PAT_W(PAT_W), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .x(x), .x_valid(x_valid), .cfg_load(cfg_load),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
    .cnt_clr(cnt_clr), .y(y), .armed(armed), .match_cnt(match_cnt)
  );

  seq_pattern_detector #(.PAT_W(PAT_W), .CNT_W(2)) dut_small (
    .clk(clk), .rst(rst), .x(x), .x_valid(x_valid), .cfg_load(cfg_load),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
    .cnt_clr(cnt_clr), .y(y2), .armed(armed2), .match_cnt(match_cnt2)
  );

  task automatic model_reset();
    m_bits.delete();
    m_armed = 1'b0;
    m_pat   = '0;
    m_len   = 0;
    m_ovl   = 1'b0;
    m_cnt   = '0;
    m_cnt2  = '0;
  endtask

  // Drive one cycle at the falling edge, predict, then compare just after the rising edge.
  task automatic step(input logic xb, input logic v, input logic ld, input logic clr,
                      input string tag);
    exp_t e;
    logic hit;
    int   n;
    @(negedge clk);
    x = xb; x_valid = v; cfg_load = ld; cnt_clr = clr;
    hit = 1'b0;
    if (ld) begin
      m_pat   = cfg_pattern;
      m_len   = (cfg_len == 0) ? 1 : ((int'(cfg_len) > PAT_W) ? PAT_W : int'(cfg_len));
      m_ovl   = cfg_overlap;
      m_armed = 1'b1;
      m_bits.delete();
    end else if (v && m_armed) begin
      m_bits.push_back(xb);
      n = m_bits.size();
      if (n >= m_len) begin
        hit = 1'b1;
        for (int i = 0; i < m_len; i++)
          if (m_bits[n - m_len + i] !== m_pat[m_len - 1 - i]) hit = 1'b0;
      end
      if (hit && !m_ovl) m_bits.delete();
    end
    if (clr) begin
      m_cnt  = hit ? 8'd1 : 8'd0;
      m_cnt2 = hit ? 2'd1 : 2'd0;
    end else if (hit) begin
      if (m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
      if (m_cnt2 != 2'd3) m_cnt2 = m_cnt2 + 2'd1;
    end
    e.y = hit; e.armed = m_armed; e.cnt = m_cnt; e.cnt2 = m_cnt2; e.tag = tag;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    n_tests++;
    if (y !== e.y || y2 !== e.y) begin
      n_fail++;
      $display("FAIL %s y: got %b/%b expected %b", e.tag, y, y2, e.y);
    end
    n_tests++;
    if (armed !== e.armed || armed2 !== e.armed) begin
      n_fail++;
      $display("FAIL %s armed: got %b/%b expected %b", e.tag, armed, armed2, e.armed);
    end
    n_tests++;
    if (match_cnt !== e.cnt || match_cnt2 !== e.cnt2) begin
      n_fail++;
      $display("FAIL %s match_cnt: got %0d/%0d expected %0d/%0d", e.tag, match_cnt,
               match_cnt2, e.cnt, e.cnt2);
    end
  endtask

  task automatic load_cfg(input logic [7:0] p, input logic [LEN_W-1:0] l, input logic o,
                          input string tag);
    cfg_pattern = p; cfg_len = l; cfg_overlap = o;
    step(1'b0, 1'b0, 1'b1, 1'b0, tag);
  endtask

  task automatic send_bits(input logic [7:0] bits, input int len, input int gap,
                           input string tag);
    logic [7:0] b;
    b = bits;
    for (int i = len - 1; i >= 0; i--) begin
      step(b[i], 1'b1, 1'b0, 1'b0, tag);
      for (int g = 0; g < gap; g++) step(1'b1, 1'b0, 1'b0, 1'b0, tag);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    x = 0; x_valid = 0; cfg_load = 0; cnt_clr = 0;
    cfg_pattern = '0; cfg_len = '0; cfg_overlap = 0;
    model_reset();
    repeat (2) @(negedge clk);
    n_tests++;
    if ({y, armed, match_cnt} !== 10'd0) begin
      n_fail++;
      $display("FAIL reset_state: got y=%b armed=%b cnt=%0d expected 0/0/0", y, armed, match_cnt);
    end
    rst = 1'b0;
    send_bits(8'b1011, 4, 0, "idle_ignores_bits");
  endtask

  task automatic test_overlap();
    load_cfg(8'b101, 4'd3, 1'b1, "ovl_load");
    send_bits(8'b10101, 5, 0, "ovl_stream");
    n_tests++;
    if (match_cnt !== 8'd2) begin
      n_fail++;
      $display("FAIL ovl_count: got %0d expected 2", match_cnt);
    end
  endtask

  task automatic test_non_overlap();
    load_cfg(8'b101, 4'd3, 1'b0, "novl_load");
    send_bits(8'b10101, 5, 0, "novl_stream");
  endtask

  task automatic test_gaps();
    load_cfg(8'hA5, 4'd8, 1'b0, "gap_load");
    send_bits(8'hA5, 8, 2, "gap_stream");
  endtask

  task automatic test_saturate();
    step(1'b0, 1'b0, 1'b0, 1'b1, "sat_clear");
    load_cfg(8'b1, 4'd1, 1'b1, "sat_load");
    send_bits(8'h3F, 6, 0, "sat_ones");
    n_tests++;
    if (match_cnt2 !== 2'd3) begin
      n_fail++;
      $display("FAIL sat_hold: got %0d expected 3", match_cnt2);
    end
    step(1'b1, 1'b1, 1'b0, 1'b1, "clr_with_match");
  endtask

  task automatic test_cfg_reload();
    load_cfg(8'b101, 4'd3, 1'b1, "reload_first");
    send_bits(8'b10, 2, 0, "reload_partial");
    cfg_pattern = 8'b011; cfg_len = 4'd3; cfg_overlap = 1'b1;
    step(1'b1, 1'b1, 1'b1, 1'b0, "reload_bit_dropped");
    send_bits(8'b1, 1, 0, "reload_tail");
    send_bits(8'b011, 3, 0, "reload_new_match");
    load_cfg(8'b1, 4'd0, 1'b1, "len0_load");
    send_bits(8'b01, 2, 0, "len0_stream");
    load_cfg(8'hFF, 4'd15, 1'b1, "len15_load");
    send_bits(8'hFF, 8, 0, "len15_stream");
  endtask

  task automatic test_back_to_back();
    load_cfg(8'b11, 4'd2, 1'b1, "b2b_load");
    send_bits(8'hF, 4, 0, "b2b_ones");
  endtask

  task automatic test_async_reset();
    load_cfg(8'b101, 4'd3, 1'b1, "arst_load");
    send_bits(8'b101, 3, 0, "arst_match");
    #2 rst = 1'b1;
    #1;
    n_tests++;
    if ({y, armed, match_cnt} !== 10'd0) begin
      n_fail++;
      $display("FAIL async_reset: got y=%b armed=%b cnt=%0d expected 0/0/0", y, armed, match_cnt);
    end
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    send_bits(8'b101, 3, 0, "arst_unarmed");
  endtask

  initial begin
    test_reset();
    test_overlap();
    test_non_overlap();
    test_gaps();
    test_saturate();
    test_cfg_reload();
    test_back_to_back();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/seq_pattern_detector.md
# seq_pattern_detector

Parametrised serial bit-pattern detector; successor to the fixed 3-bit "101" Moore detector. Matches a runtime-programmable pattern of 1..PAT_W bits on a qualified serial input, supports overlapping and non-overlapping detection, and keeps a saturating match count. Sits between a serial line front-end and control logic that needs a registered match strobe plus statistics.

## Interface
- PAT_W, 8, maximum pattern length in bits (>=2)
- CNT_W, 8, match counter width
- LEN_W, $clog2(PAT_W+1), derived, width of length field (not to be overridden)

- clk  in  1  single clock, all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high; clears all state and outputs
- x  in  1  serial data bit
- x_valid  in  1  x sampled only on edges where x_valid=1
- cfg_load  in  1  latch cfg_pattern/cfg_len/cfg_overlap, clear history
- cfg_pattern  in  PAT_W  pattern; bit cfg_len-1 = first bit received, bit 0 = last
- cfg_len  in  LEN_W  pattern length; 0 -> 1, >PAT_W -> PAT_W (clamped at load)
- cfg_overlap  in  1  1 = overlapping matches allowed, 0 = history flushed after each match
- cnt_clr  in  1  synchronous clear of match_cnt
- y  out  1  registered match strobe
- armed  out  1  high when a configuration is loaded and FSM is not IDLE
- match_cnt  out  CNT_W  saturating count of matches

## Operation
- Registers: pat, len, ovl (config); hist[PAT_W-1:0] shift register, newest bit in hist[0]; fill counter 0..len.
- FSM states: IDLE, FILL, DETECT.
  - IDLE: after reset; ignores x_valid. cfg_load -> FILL.
  - FILL: each valid bit shifts into hist, fill++; when fill reaches len -> DETECT (that same edge also evaluates a match).
  - DETECT: each valid bit shifts in; match = (hist_next[len-1:0] == pat[len-1:0]).
  - On match with ovl=0: fill <= 0, hist <= 0, state -> FILL. With ovl=1: stay DETECT.
  - cfg_load in FILL/DETECT: reload config, fill <= 0, hist <= 0, -> FILL.
- y <= match on the sampling edge; otherwise 0. Single-cycle pulse per match.
- match_cnt increments on each match, saturates at 2^CNT_W-1 (no wrap).
- Priority per edge: rst > cfg_load > x_valid. A bit presented with cfg_load is discarded.
- cnt_clr with simultaneous match: match_cnt <= 1 (clear then count).
- Comparison uses only the low len bits; upper hist bits are don't-care.

## Timing
- Reset values: y=0, armed=0, match_cnt=0, state=IDLE, hist=0, fill=0, config regs=0.
- Latency: y high in the cycle immediately after the edge sampling the final pattern bit; one clock wide.
- Back-to-back valid bits: supported every cycle; overlapping matches can pulse y on consecutive cycles (e.g., pattern "11", ovl=1).
- x_valid low: hist, fill, state unchanged; y=0.
- armed rises the cycle after cfg_load.
- Async rst mid-stream: immediate clear; config lost, cfg_load required again.

## Structure
- Package seq_det_pkg: state enum (IDLE/FILL/DETECT), LEN_W calculation function, clamp function for cfg_len.
- One sub-module: sat_counter (parametrised CNT_W, inc, clr, clear-then-increment semantics).
- Rest (FSM, shift register, compare mask) in the top module.

## Test plan
- PAT_W=8, load pattern 3'b101 len=3 ovl=1, stream 1,0,1,0,1 -> y pulses after bits 3 and 5, match_cnt=2.
- Same stream, ovl=0 -> single y pulse after bit 3, match_cnt=1.
- Load 8'hA5 len=8, send 0xA5 MSB-first with x_valid gaps of 2 cycles -> one y pulse after last bit, none during gaps.
- CNT_W=2, pattern "1" len=1, stream 6 ones -> match_cnt 1,2,3,3,3,3; cnt_clr on a match edge -> match_cnt=1.
- cfg_load mid-pattern (after 2 of 3 bits) with new pattern, then remaining bit -> no match; bit on cfg_load edge ignored; cfg_len=0 -> behaves as len 1, cfg_len=15 -> clamped to 8.
- Assert rst mid-DETECT -> y=0, armed=0, match_cnt=0 immediately; valid bits ignored until cfg_load.
